// File: rtl/clm_sq_chain_pkg.sv
// Shared types and constants for the masked squaring chain.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package clm_sq_chain_pkg;

    localparam int CLM_D = 2;                  // default redundancy bits
    localparam int GF_W  = 8;                  // field width, GF(2^8)

    // Derived widths for the default redundancy
    localparam int LANE_W = GF_W + CLM_D;      // lane state width
    localparam int NM_ROWS = 7 + 2 * CLM_D;    // rows of extended reduction matrix

    typedef logic [LANE_W-1:0]            state_t;
    typedef logic [CLM_D-1:0]             red_poly_t;
    typedef logic [NM_ROWS-1:0][GF_W-1:0] nm_matrix_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } clm_sq_state_e;

    // Lane width for an arbitrary redundancy
    function automatic int lane_w(input int d);
        return GF_W + d;
    endfunction

endpackage

// File: rtl/clm_sq_step.sv
// One masked squaring step of a single lane in the redundant representation.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is registered.
module clm_sq_step
    import clm_sq_chain_pkg::*;
#(
    parameter int D = CLM_D
) (
    input  logic [8+D-1:0]          x,
    input  logic [D-1:0]            r,
    input  logic [7+2*D-1:0][7:0]   b_ext,
    output logic [8+D-1:0]          y
);

    localparam int W  = 8 + D;
    localparam int SW = 15 + 2 * D;     // spread width, indices 0 .. 14+2D
    localparam int NR = 7 + 2 * D;      // matrix rows: high spread bits then r

    logic [SW-1:0] s;
    logic [NR-1:0] v;
    logic [W-1:0]  t;
    logic          acc;

    // Squaring spreads the coefficients; high terms and the refresh are folded back via b_ext
    always_comb begin
        s   = '0;
        t   = '0;
        acc = 1'b0;
        for (int i = 0; i < W; i++) begin
            s[2*i] = x[i];
        end
        v = {r, s[SW-1:W]};
        for (int j = 0; j < 8; j++) begin
            acc = 1'b0;
            for (int m = 0; m < NR; m++) begin
                acc = acc ^ (v[m] & b_ext[m][j]);
            end
            t[j] = acc;
        end
        for (int j = 0; j < D; j++) begin
            t[8+j] = r[j];
        end
        y = s[W-1:0] ^ t;
    end

endmodule

// File: rtl/clm_sq_chain.sv
// Iterated masked squaring x^(2^k) over GF(2^8), N_LANES lanes in lockstep.
// Latency: k+1 cycles from the accept cycle to out_valid with randomness always offered (1 for k=0).
// Backpressure: a missing rnd_valid stalls the chain; out_ready low holds the result and blocks new accepts.
module clm_sq_chain
    import clm_sq_chain_pkg::*;
#(
    parameter int D       = CLM_D,
    parameter int N_LANES = 1,
    parameter int KW      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_LANES*(8+D)-1:0]    in_data,
    input  logic [KW-1:0]               in_k,
    input  logic                        rnd_valid,
    output logic                        rnd_ready,
    input  logic [N_LANES*D-1:0]        rnd_data,
    input  logic [7+2*D-1:0][7:0]       b_ext,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N_LANES*(8+D)-1:0]    out_data
);

    localparam int W = 8 + D;

    clm_sq_state_e              state_q, state_d;
    logic [KW-1:0]              cnt_q;
    logic [N_LANES*W-1:0]       lanes_q;
    logic [N_LANES*W-1:0]       step_out;

    // All lanes share the reduction matrix but each gets its own refresh slice
    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        clm_sq_step #(.D(D)) u_step (
            .x     (lanes_q[l*W +: W]),
            .r     (rnd_data[l*D +: D]),
            .b_ext (b_ext),
            .y     (step_out[l*W +: W])
        );
    end

    // Next-state: accept in IDLE, count steps in RUN, wait for consumer in DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = (in_k == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (rnd_valid && cnt_q == KW'(1)) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshakes follow the state; lane shares are only exposed while DONE
    always_comb begin
        in_ready  = (state_q == ST_IDLE) && !rst;
        rnd_ready = (state_q == ST_RUN);
        out_valid = (state_q == ST_DONE);
        out_data  = (state_q == ST_DONE) ? lanes_q : '0;
    end

    // State, step counter and lane registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lanes_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && in_valid) begin
                lanes_q <= in_data;
                cnt_q   <= in_k;
            end else if (state_q == ST_RUN && rnd_valid) begin
                lanes_q <= step_out;
                cnt_q   <= cnt_q - KW'(1);
            end
        end
    end

endmodule

// File: tb/tb_clm_sq_chain.sv
// Bench for clm_sq_chain: table-driven operations with a reference step model and scoreboard.
// Latency: checks accept-to-result cycle counts including randomness stalls.
// Backpressure: exercises rnd_valid stalls, out_ready hold-off and reset mid-run.
module tb_clm_sq_chain;

    localparam int NL = 4;
    localparam int W  = 10;

    logic                   clk, rst;
    logic                   in_valid, in_ready;
    logic [NL*W-1:0]        in_data;
    logic [3:0]             in_k;
    logic                   rnd_valid, rnd_ready;
    logic [NL*2-1:0]        rnd_data;
    logic [10:0][7:0]       b_ext, b_ref;
    logic                   out_valid, out_ready;
    logic [NL*W-1:0]        out_data;

    int n_chk = 0;
    int n_pass = 0;
    logic [NL*W-1:0] exp_q[$];
    logic [31:0]     can_q[$];

    clm_sq_chain #(.D(2), .N_LANES(NL), .KW(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_k(in_k),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
        .b_ext(b_ext),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The reduction matrix must not move while the engine is stepping
    always @(posedge clk) begin
        if (!rst && rnd_ready) begin
            assert (b_ext == b_ref) else $error("b_ext changed while busy");
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", nm, act, req);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    // alpha^n reduced modulo the AES polynomial
    function automatic logic [7:0] red(input int n);
        logic [7:0] a = 8'h01;
        for (int q = 0; q < n; q++) a = xt(a);
        return a;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int q = 0; q < 8; q++) begin
            if (b[q]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // Squaring: coefficient i moves to exponent 2i; exponents >= 10 reduce, 8 stays redundant.
    // Refresh r_j adds alpha^(8+j) redundantly and its reduced form in the low byte.
    function automatic logic [9:0] m_step(input logic [9:0] x, input logic [1:0] r);
        logic [7:0] lo = 8'h00;
        logic [1:0] hi = 2'b00;
        for (int i = 0; i < 10; i++) begin
            if (x[i]) begin
                if (2*i == 8) hi[0] = ~hi[0];
                else lo = lo ^ red(2*i);
            end
        end
        for (int j = 0; j < 2; j++) begin
            if (r[j]) begin
                hi[j] = ~hi[j];
                lo = lo ^ red(8+j);
            end
        end
        return {hi, lo};
    endfunction

    function automatic logic [7:0] canon(input logic [9:0] x);
        return x[7:0] ^ (x[8] ? red(8) : 8'h00) ^ (x[9] ? red(9) : 8'h00);
    endfunction

    function automatic logic [7:0] pow2k(input logic [7:0] a, input int k);
        logic [7:0] p = a;
        for (int q = 0; q < k; q++) p = gmul(p, p);
        return p;
    endfunction

    // ---------------- one complete operation ----------------
    typedef struct {
        string       nm;
        logic [39:0] x;
        logic [3:0]  k;
        bit          rz;
        bit          stall;
        int          bp;
    } vec_t;

    task automatic do_op(input vec_t v);
        logic [7:0]  rl[$];
        logic [7:0]  rt;
        logic [39:0] e, got, held;
        logic [31:0] cexp, cgot;
        logic [9:0]  ln;
        int idx, stalls, lat, p, w;
        bit seen, leak, stable, done;

        for (int s = 0; s < int'(v.k); s++) rl.push_back(v.rz ? 8'h00 : 8'($urandom));
        for (int l = 0; l < NL; l++) begin
            ln = v.x[l*W +: W];
            for (int s = 0; s < int'(v.k); s++) begin
                rt = rl[s];
                ln = m_step(ln, rt[l*2 +: 2]);
            end
            e[l*W +: W] = ln;
            cexp[l*8 +: 8] = pow2k(canon(v.x[l*W +: W]), int'(v.k));
        end
        exp_q.push_back(e);
        can_q.push_back(cexp);

        seen = 0;
        for (w = 0; w < 20 && !seen; w++) begin
            @(negedge clk);
            seen = in_ready;
        end
        chk({v.nm, " ready"}, 64'(seen), 64'd1);
        if (!seen) begin
            void'(exp_q.pop_front());
            void'(can_q.pop_front());
            return;
        end
        in_valid = 1'b1;
        in_data  = v.x;
        in_k     = v.k;

        idx = 0; stalls = 0; lat = 0; p = 0; leak = 0; done = 0;
        for (int n = 1; n < 200 && !done; n++) begin
            @(negedge clk);
            if (n == 1) begin
                in_valid = 1'b0;
                in_k     = 4'($urandom);
                in_data  = 40'($urandom);
            end
            if (out_valid) begin
                lat = n;
                done = 1;
            end else begin
                if (out_data != '0) leak = 1;
                if (rnd_ready) begin
                    rnd_valid = v.stall ? (p % 3 == 0) : 1'b1;
                    p++;
                    rnd_data = (idx < rl.size()) ? rl[idx] : 8'($urandom);
                    if (rnd_valid) idx++;
                    else stalls++;
                end else begin
                    rnd_valid = 1'b0;
                end
            end
        end
        rnd_valid = 1'b0;
        chk({v.nm, " finished"}, 64'(done), 64'd1);
        chk({v.nm, " steps"}, 64'(idx), 64'(v.k));
        chk({v.nm, " latency"}, 64'(lat), 64'(1 + int'(v.k) + stalls));
        chk({v.nm, " no leak"}, 64'(leak), 64'd0);

        held = out_data;
        stable = 1;
        if (v.bp > 0) begin
            in_valid = 1'b1;
            in_k     = 4'd3;
            for (int b = 0; b < v.bp; b++) begin
                @(negedge clk);
                if (!out_valid || out_data != held || in_ready) stable = 0;
            end
            in_valid = 1'b0;
            chk({v.nm, " hold stable"}, 64'(stable), 64'd1);
        end

        got = held;
        for (int l = 0; l < NL; l++) cgot[l*8 +: 8] = canon(got[l*W +: W]);
        chk({v.nm, " data"}, 64'(got), 64'(exp_q.pop_front()));
        chk({v.nm, " canonical"}, 64'(cgot), 64'(can_q.pop_front()));

        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({v.nm, " back idle"}, {61'd0, out_valid, in_ready, |out_data}, {61'd0, 1'b0, 1'b1, 1'b0});
    endtask

    // ---------------- stimulus ----------------
    vec_t tbl[9];
    int   idx6;

    initial begin
        for (int m = 0; m < 9; m++) b_ref[m] = red(10 + m);
        b_ref[9]  = red(8);
        b_ref[10] = red(9);
        b_ext = b_ref;

        rst = 1'b1; in_valid = 0; in_data = '0; in_k = '0;
        rnd_valid = 0; rnd_data = '0; out_ready = 0;

        tbl[0] = '{"T1 passthru", {4{10'h0A5}}, 4'd0, 1'b1, 1'b0, 0};
        tbl[1] = '{"T2 fermat",   {4{10'h053}}, 4'd8, 1'b1, 1'b0, 0};
        tbl[2] = '{"T3 refresh",  40'h0,        4'd5, 1'b0, 1'b0, 0};
        tbl[3] = '{"k1",          40'h0,        4'd1, 1'b0, 1'b0, 0};
        tbl[4] = '{"k15 max",     40'h0,        4'd15, 1'b0, 1'b0, 0};
        tbl[5] = '{"redundant in",40'h0,        4'd2, 1'b0, 1'b0, 0};
        tbl[6] = '{"T4 stall",    40'h0,        4'd3, 1'b0, 1'b1, 0};
        tbl[7] = '{"T5 backpress",40'h0,        4'd4, 1'b0, 1'b0, 10};
        tbl[8] = '{"after reset", 40'h0,        4'd6, 1'b0, 1'b0, 0};
        for (int t = 2; t < 9; t++) begin
            for (int l = 0; l < NL; l++) begin
                tbl[t].x[l*W +: W] = (t == 5) ? 10'($urandom) : {2'b00, 8'($urandom)};
            end
        end

        // reset state
        @(negedge clk);
        chk("reset outputs", {24'd0, in_ready, rnd_ready, out_valid, 1'b0, out_data},
            {24'd0, 4'b0000, 40'd0});
        rst = 1'b0;
        @(negedge clk);
        chk("ready after reset", 64'(in_ready), 64'd1);

        for (int t = 0; t < 8; t++) do_op(tbl[t]);

        // T6: reset while two squarings remain of a six-step run
        @(negedge clk);
        in_valid = 1'b1; in_k = 4'd6; in_data = 40'($urandom);
        idx6 = 0;
        for (int n = 1; n < 50 && idx6 < 4; n++) begin
            @(negedge clk);
            if (n == 1) in_valid = 1'b0;
            if (idx6 < 4 && rnd_ready) begin
                rnd_valid = 1'b1;
                rnd_data = 8'($urandom);
                idx6++;
            end
        end
        @(negedge clk);
        chk("T6 running before reset", 64'(rnd_ready), 64'd1);
        rst = 1'b1;
        #1;
        chk("T6 reset outputs", {24'd0, in_ready, rnd_ready, out_valid, 1'b0, out_data},
            {24'd0, 4'b0000, 40'd0});
        rnd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("T6 ready after release", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
        do_op(tbl[8]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
